// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_pkg                                                                    |
// | Shared FP field widths, unpacked-operand types and the operand unpacker.   |
// | Config macro: FPU_DENORM_EN (gradual underflow instead of flush-to-zero).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 4;
  localparam int BIAS   = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_fields_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_unpacked_t;

  // Builds {hidden, frac, G, R, S}; neg inverts the sign (used for B under subtraction).
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x, input logic neg);
    fp_fields_t   f;
    fp_unpacked_t u;
    f      = fp_fields_t'(x);
    u.sign = f.sign ^ neg;
`ifdef FPU_DENORM_EN
    u.exp  = (f.exp == '0) ? EXP_W'(1) : f.exp;
    u.mant = {(f.exp != '0), f.frac, 3'b000};
`else
    u.exp  = f.exp;
    u.mant = (f.exp == '0) ? '0 : {1'b1, f.frac, 3'b000};
`endif
    return u;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_align_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_align_shifter                                                          |
// | Combinational mantissa right shift; bits shifted out collapse into bit 0.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fpu_align_shifter
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0] mant_in,
  input  logic [EXP_W-1:0]  shamt,
  output logic [MANT_W-1:0] mant_out
);

  localparam logic [EXP_W-1:0] c_shamt_max = EXP_W'(MANT_W);

  logic [MANT_W-1:0] w_mask;
  logic [MANT_W-1:0] w_shr;
  logic              w_sticky;

  assign w_mask   = ~({MANT_W{1'b1}} << shamt);
  assign w_shr    = mant_in >> shamt;
  assign w_sticky = |(mant_in & w_mask);

  always_comb begin
    mant_out = {w_shr[MANT_W-1:1], w_shr[0] | w_sticky};
    if (shamt >= c_shamt_max) begin
      mant_out = {{(MANT_W-1){1'b0}}, |mant_in};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_align_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_align_stage                                                            |
// | FP add/sub front end: unpack, magnitude swap, sticky-preserving alignment. |
// | Two-entry valid/ready pipeline. Config macro: FPU_DENORM_EN.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fpu_align_stage
  import fpu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FRAC_W+3:0]   mant_big,
  output logic [FRAC_W+3:0]   mant_small,
  output logic [EXP_W-1:0]    exp_big,
  output logic                sign_big,
  output logic                eff_sub,
  output logic                swap
);

  fp_unpacked_t w_ua;
  fp_unpacked_t w_ub;
  fp_unpacked_t w_big;
  fp_unpacked_t w_small;
  logic         w_swap;
  logic [EXP_W-1:0]  w_diff;
  logic [FRAC_W+3:0] w_shifted;

  logic              r_s1_v;
  logic [FRAC_W+3:0] r_s1_mant_big;
  logic [FRAC_W+3:0] r_s1_mant_small;
  logic [EXP_W-1:0]  r_s1_exp_big;
  logic [EXP_W-1:0]  r_s1_diff;
  logic              r_s1_sign;
  logic              r_s1_eff_sub;
  logic              r_s1_swap;
  logic              r_s2_v;

  logic w_s1_load;
  logic w_s1_adv;
  logic w_s2_open;

  assign w_ua = fp_unpack(a, 1'b0);
  assign w_ub = fp_unpack(b, op);

  // Compare on raw {exp,frac}; a tie keeps A as the big operand.
  assign w_swap  = b[WIDTH-2:0] > a[WIDTH-2:0];
  assign w_big   = w_swap ? w_ub : w_ua;
  assign w_small = w_swap ? w_ua : w_ub;
  assign w_diff  = w_big.exp - w_small.exp;

  assign w_s2_open = ~r_s2_v | out_ready;
  assign w_s1_adv  = r_s1_v & w_s2_open;
  assign in_ready  = ~r_s1_v | w_s1_adv;
  assign w_s1_load = in_valid & in_ready;
  assign out_valid = r_s2_v;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_s1_v          <= 1'b0;
      r_s1_mant_big   <= '0;
      r_s1_mant_small <= '0;
      r_s1_exp_big    <= '0;
      r_s1_diff       <= '0;
      r_s1_sign       <= 1'b0;
      r_s1_eff_sub    <= 1'b0;
      r_s1_swap       <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_v <= in_valid;
      end
      if (w_s1_load) begin
        r_s1_mant_big   <= w_big.mant;
        r_s1_mant_small <= w_small.mant;
        r_s1_exp_big    <= w_big.exp;
        r_s1_diff       <= w_diff;
        r_s1_sign       <= w_big.sign;
        r_s1_eff_sub    <= a[WIDTH-1] ^ b[WIDTH-1] ^ op;
        r_s1_swap       <= w_swap;
      end
    end
  end

  fpu_align_shifter u_shifter (
    .mant_in  (r_s1_mant_small),
    .shamt    (r_s1_diff),
    .mant_out (w_shifted)
  );

  // Output registers only move when stage 2 is free, so they hold under backpressure.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_s2_v     <= 1'b0;
      mant_big   <= '0;
      mant_small <= '0;
      exp_big    <= '0;
      sign_big   <= 1'b0;
      eff_sub    <= 1'b0;
      swap       <= 1'b0;
    end else if (w_s2_open) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        mant_big   <= r_s1_mant_big;
        mant_small <= w_shifted;
        exp_big    <= r_s1_exp_big;
        sign_big   <= r_s1_sign;
        eff_sub    <= r_s1_eff_sub;
        swap       <= r_s1_swap;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_align_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fpu_align_stage                                                         |
// | Directed self-checking bench for fpu_align_stage (honours FPU_DENORM_EN).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fpu_align_stage;

  logic        clk;
  logic        arst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] mant_big;
  logic [26:0] mant_small;
  logic [7:0]  exp_big;
  logic        sign_big;
  logic        eff_sub;
  logic        swap;

  int n_total;
  int n_bad;

  fpu_align_stage dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .exp_big    (exp_big),
    .sign_big   (sign_big),
    .eff_sub    (eff_sub),
    .swap       (swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // One isolated transaction with out_ready high; checks latency then every field.
  task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vop, input logic e_swap, input logic [7:0] e_exp,
                         input logic [26:0] e_mbig, input logic [26:0] e_msmall,
                         input logic e_sign, input logic e_esub);
    @(negedge clk);
    a = va; b = vb; op = vop; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_swap"},     32'(swap),       32'(e_swap));
    chk({tag, "_exp_big"},  32'(exp_big),    32'(e_exp));
    chk({tag, "_mant_big"}, 32'(mant_big),   32'(e_mbig));
    chk({tag, "_mant_sm"},  32'(mant_small), 32'(e_msmall));
    chk({tag, "_sign_big"}, 32'(sign_big),   32'(e_sign));
    chk({tag, "_eff_sub"},  32'(eff_sub),    32'(e_esub));
    @(negedge clk);
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] va [4];
  logic [31:0] vb [4];
  logic [7:0]  ve_exp [4];
  logic [26:0] ve_small [4];
  logic [26:0] ve_big [4];
  logic [26:0] w5_small;

  initial begin
    n_total = 0; n_bad = 0;
    arst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mant_big",  32'(mant_big),  32'd0);
    chk("rst_exp_big",   32'(exp_big),   32'd0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_vec("t1", 32'h3F800000, 32'h40000000, 1'b0, 1'b1, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0);
    run_vec("t2", 32'h3F800000, 32'h33800000, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0000004, 1'b0, 1'b0);
    run_vec("t3", 32'h4F800000, 32'h3F800001, 1'b0, 1'b0, 8'h9F, 27'h4000000, 27'h0000001, 1'b0, 1'b0);
    run_vec("t4", 32'h40400000, 32'h40400000, 1'b1, 1'b0, 8'h80, 27'h6000000, 27'h6000000, 1'b0, 1'b1);
`ifdef FPU_DENORM_EN
    w5_small = 27'h0000008;
`else
    w5_small = 27'h0000000;
`endif
    run_vec("t5", 32'h00000001, 32'h00800000, 1'b0, 1'b1, 8'h01, 27'h4000000, w5_small, 1'b0, 1'b0);
    run_vec("neg", 32'h3F800000, 32'hC0000000, 1'b0, 1'b1, 8'h80, 27'h4000000, 27'h2000000, 1'b1, 1'b1);
    run_vec("negsub", 32'h3F800000, 32'hC0000000, 1'b1, 1'b1, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0);
    run_vec("zero", 32'h40000000, 32'h00000000, 1'b0, 1'b0, 8'h80, 27'h4000000, 27'h0000000, 1'b0, 1'b0);

    // Back-to-back burst under 5+ cycles of output backpressure.
    va[0] = 32'h3F800000; vb[0] = 32'h40000000; ve_exp[0] = 8'h80; ve_big[0] = 27'h4000000; ve_small[0] = 27'h2000000;
    va[1] = 32'h3F800000; vb[1] = 32'h33800000; ve_exp[1] = 8'h7F; ve_big[1] = 27'h4000000; ve_small[1] = 27'h0000004;
    va[2] = 32'h4F800000; vb[2] = 32'h3F800001; ve_exp[2] = 8'h9F; ve_big[2] = 27'h4000000; ve_small[2] = 27'h0000001;
    va[3] = 32'h40400000; vb[3] = 32'h40400000; ve_exp[3] = 8'h80; ve_big[3] = 27'h6000000; ve_small[3] = 27'h6000000;
    begin
      int n_in;
      int n_out;
      n_in = 0; n_out = 0;
      op = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk);
        out_ready = (cyc >= 7);
        in_valid  = (n_in < 4);
        a = (n_in < 4) ? va[n_in] : 32'h0;
        b = (n_in < 4) ? vb[n_in] : 32'h0;
        #1;
        if (cyc >= 2 && cyc <= 6) begin
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_hold_valid", 32'(out_valid), 32'd1);
          chk("bp_hold_small", 32'(mant_small), 32'(ve_small[0]));
          chk("bp_hold_exp", 32'(exp_big), 32'(ve_exp[0]));
        end
        if (out_valid && out_ready) begin
          chk("burst_exp", 32'(exp_big), 32'(ve_exp[n_out]));
          chk("burst_big", 32'(mant_big), 32'(ve_big[n_out]));
          chk("burst_small", 32'(mant_small), 32'(ve_small[n_out]));
          n_out++;
        end
        if (in_valid && in_ready) n_in++;
        if (n_out == 4) break;
      end
      chk("burst_count", 32'(n_out), 32'd4);
    end

    // Async reset with two entries in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = va[0]; b = vb[0];
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_mant", 32'(mant_big), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
